// File: rtl/alu_uart_pkg.sv
// Shared types and defaults for the UART-to-ALU command path.
package alu_uart_pkg;

   // Frame reception states.
   typedef enum logic [2:0] {
      HUNT,
      OPCODE,
      OPA,
      OPB,
      CHECK
   } state_e;

   // Error codes reported on err_code alongside the err strobe.
   typedef enum logic [1:0] {
      ERR_OPCODE  = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_OVF     = 2'd3
   } err_code_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, pulses expired for one cycle.
module rx_gap_timer #(
   parameter int unsigned TIMEOUT_CLKS = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
   // Count value during the final idle cycle before the gap limit is hit.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CLKS - 1);

   logic [CNT_W-1:0] cnt;

   // A byte in the expiry cycle (clear) suppresses the expiry.
   always_comb begin
      expired = enable && !clear && (cnt == LAST_CNT);
   end

   // Gap counter: held at zero when disabled, cleared on every byte and on expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || !enable || expired) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_cmd_decoder.sv
// Byte-stream frame decoder: sync, opcode, A, B, checksum -> validated ALU command.
module alu_cmd_decoder
   import alu_uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CLKS = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [3:0]        cmd_op,
   output logic [DATA_W-1:0] cmd_a,
   output logic [DATA_W-1:0] cmd_b,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned NB        = DATA_W / 8;
   localparam logic [1:0]  LAST_BYTE = 2'(NB - 1);

   state_e            state;
   logic [1:0]        byte_cnt;
   logic [3:0]        op_sh;
   logic [DATA_W-1:0] a_sh;
   logic [DATA_W-1:0] b_sh;
   logic [7:0]        csum;
   logic              op_bad;

   logic timer_en;
   logic expired;
   logic csum_ok;
   logic can_load;
   logic accept;

   // Frame-level decode terms shared by the state register below.
   always_comb begin
      timer_en = (state != HUNT);
      csum_ok  = (rx_data == csum);
      accept   = cmd_valid && cmd_ready;
      // A new command may replace the pending one only if that one is being taken now.
      can_load = !cmd_valid || cmd_ready;
   end

   rx_gap_timer #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_gap_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (rx_valid),
      .enable  (timer_en),
      .expired (expired)
   );

   // Frame FSM, operand/checksum assembly, command output and registered error strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HUNT;
         byte_cnt  <= '0;
         op_sh     <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         csum      <= '0;
         op_bad    <= 1'b0;
         cmd_op    <= '0;
         cmd_a     <= '0;
         cmd_b     <= '0;
         cmd_valid <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
      end else begin
         err <= 1'b0;
         // A commit in the CHECK branch below overrides this drop.
         if (accept) begin
            cmd_valid <= 1'b0;
         end

         if (expired) begin
            state    <= HUNT;
            byte_cnt <= '0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
         end else if (rx_valid) begin
            unique case (state)
               HUNT: begin
                  if (rx_data == SYNC_BYTE) begin
                     state <= OPCODE;
                  end
               end
               OPCODE: begin
                  op_sh    <= rx_data[3:0];
                  op_bad   <= (rx_data[7:4] != 4'd0);
                  csum     <= rx_data;
                  byte_cnt <= '0;
                  state    <= OPA;
               end
               OPA: begin
                  a_sh <= (a_sh << 8) | DATA_W'(rx_data);
                  csum <= csum ^ rx_data;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     state    <= OPB;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
               OPB: begin
                  b_sh <= (b_sh << 8) | DATA_W'(rx_data);
                  csum <= csum ^ rx_data;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     state    <= CHECK;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
               CHECK: begin
                  state <= HUNT;
                  if (op_bad) begin
                     err      <= 1'b1;
                     err_code <= ERR_OPCODE;
                  end else if (!csum_ok) begin
                     err      <= 1'b1;
                     err_code <= ERR_CSUM;
                  end else if (can_load) begin
                     cmd_op    <= op_sh;
                     cmd_a     <= a_sh;
                     cmd_b     <= b_sh;
                     cmd_valid <= 1'b1;
                  end else begin
                     err      <= 1'b1;
                     err_code <= ERR_OVF;
                  end
               end
               default: begin
                  state <= HUNT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_decoder.sv
// Scoreboard bench for alu_cmd_decoder: an 8-bit and a 16-bit instance.
module tb_alu_cmd_decoder;

   localparam int unsigned TO = 50000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid8, rx_valid16;
   logic        ready8, ready16;

   logic [3:0]  op8, op16;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic        cv8, cv16, err8, err16;
   logic [1:0]  code8, code16;

   typedef struct packed {
      logic        is_err;
      logic [1:0]  code;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } evt_t;

   evt_t q8[$];
   evt_t q16[$];
   evt_t last8, last16;
   int   errors = 0;
   int   checks = 0;
   logic pv8, pa8, pv16, pa16;

   always #5 clk = ~clk;

   alu_cmd_decoder #(
      .DATA_W       (8),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (TO)
   ) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid8),
      .cmd_op    (op8),
      .cmd_a     (a8),
      .cmd_b     (b8),
      .cmd_valid (cv8),
      .cmd_ready (ready8),
      .err       (err8),
      .err_code  (code8)
   );

   alu_cmd_decoder #(
      .DATA_W       (16),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (TO)
   ) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid16),
      .cmd_op    (op16),
      .cmd_a     (a16),
      .cmd_b     (b16),
      .cmd_valid (cv16),
      .cmd_ready (ready16),
      .err       (err16),
      .err_code  (code16)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic push_cmd(input bit wide, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b);
      evt_t e;
      e = '{is_err: 1'b0, code: 2'd0, op: op, a: a, b: b};
      if (wide) q16.push_back(e);
      else      q8.push_back(e);
   endtask

   task automatic push_err(input bit wide, input logic [1:0] code);
      evt_t e;
      e = '{is_err: 1'b1, code: code, op: 4'd0, a: 16'd0, b: 16'd0};
      if (wide) q16.push_back(e);
      else      q8.push_back(e);
   endtask

   // Pop the next expected event for one instance and compare with what it presented.
   task automatic observe(input bit wide, input evt_t got);
      evt_t exp;
      checks++;
      if ((wide && q16.size() == 0) || (!wide && q8.size() == 0)) begin
         errors++;
         $display("FAIL unexpected_event w%0d: got %h expected none", wide, got);
      end else begin
         exp = wide ? q16.pop_front() : q8.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL event w%0d: got %h expected %h", wide, got, exp);
         end
         if (!exp.is_err) begin
            if (wide) last16 = exp;
            else      last8  = exp;
         end
      end
   endtask

   // Monitor for the 8-bit instance: errors, newly presented commands, held outputs.
   always @(negedge clk) begin
      if (rst) begin
         pv8 <= 1'b0;
         pa8 <= 1'b0;
      end else begin
         if (err8) observe(1'b0, '{1'b1, code8, 4'd0, 16'd0, 16'd0});
         if (cv8 && (!pv8 || pa8)) begin
            observe(1'b0, '{1'b0, 2'd0, op8, {8'd0, a8}, {8'd0, b8}});
         end else if (cv8) begin
            chk("hold_op8", {28'd0, op8}, {28'd0, last8.op});
            chk("hold_a8", {24'd0, a8}, {16'd0, last8.a});
            chk("hold_b8", {24'd0, b8}, {16'd0, last8.b});
         end
         pv8 <= cv8;
         pa8 <= cv8 && ready8;
      end
   end

   // Monitor for the 16-bit instance.
   always @(negedge clk) begin
      if (rst) begin
         pv16 <= 1'b0;
         pa16 <= 1'b0;
      end else begin
         if (err16) observe(1'b1, '{1'b1, code16, 4'd0, 16'd0, 16'd0});
         if (cv16 && (!pv16 || pa16)) begin
            observe(1'b1, '{1'b0, 2'd0, op16, a16, b16});
         end else if (cv16) begin
            chk("hold_op16", {28'd0, op16}, {28'd0, last16.op});
            chk("hold_a16", {16'd0, a16}, {16'd0, last16.a});
            chk("hold_b16", {16'd0, b16}, {16'd0, last16.b});
         end
         pv16 <= cv16;
         pa16 <= cv16 && ready16;
      end
   end

   // Present one byte; rx_valid stays high so consecutive calls are back-to-back.
   task automatic send(input bit wide, input logic [7:0] b);
      rx_data    = b;
      rx_valid8  = !wide;
      rx_valid16 = wide;
      @(posedge clk);
      #1;
   endtask

   task automatic stop_rx();
      rx_valid8  = 1'b0;
      rx_valid16 = 1'b0;
   endtask

   task automatic send_frame8(input logic [7:0] f [5]);
      for (int i = 0; i < 5; i++) send(1'b0, f[i]);
      stop_rx();
   endtask

   initial begin
      logic [7:0] fr [5];
      rst        = 1'b1;
      rx_data    = 8'd0;
      rx_valid8  = 1'b0;
      rx_valid16 = 1'b0;
      ready8     = 1'b0;
      ready16    = 1'b0;
      last8      = '0;
      last16     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid8", {31'd0, cv8}, 32'd0);
      chk("rst_op8", {28'd0, op8}, 32'd0);
      chk("rst_a8", {24'd0, a8}, 32'd0);
      chk("rst_b8", {24'd0, b8}, 32'd0);
      chk("rst_err8", {31'd0, err8}, 32'd0);
      chk("rst_code8", {30'd0, code8}, 32'd0);
      chk("rst_valid16", {31'd0, cv16}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic frame, held until accepted.
      push_cmd(1'b0, 4'd3, 16'h12, 16'h34);
      fr = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h25};
      send_frame8(fr);
      chk("latency_valid8", {31'd0, cv8}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("held_valid8", {31'd0, cv8}, 32'd1);
      ready8 = 1'b1;
      @(posedge clk);
      #1;
      ready8 = 1'b0;
      chk("accept_drop8", {31'd0, cv8}, 32'd0);

      // Junk before sync is silent; bad checksum.
      push_err(1'b0, 2'd1);
      send(1'b0, 8'h00);
      send(1'b0, 8'h7F);
      fr = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h26};
      send_frame8(fr);
      chk("csum_err8", {31'd0, err8}, 32'd1);
      chk("csum_code8", {30'd0, code8}, 32'd1);
      chk("csum_nocmd8", {31'd0, cv8}, 32'd0);
      @(posedge clk);
      #1;
      chk("err_one_cycle8", {31'd0, err8}, 32'd0);
      chk("err_code_hold8", {30'd0, code8}, 32'd1);

      // Bad opcode high nibble (checksum itself is correct).
      push_err(1'b0, 2'd0);
      fr = '{8'hA5, 8'h13, 8'h12, 8'h34, 8'h35};
      send_frame8(fr);
      chk("op_err8", {31'd0, err8}, 32'd1);
      chk("op_code8", {30'd0, code8}, 32'd0);

      // Inter-byte timeout, then a clean frame.
      push_err(1'b0, 2'd2);
      send(1'b0, 8'hA5);
      send(1'b0, 8'h03);
      send(1'b0, 8'h12);
      stop_rx();
      repeat (TO - 1) @(posedge clk);
      #1;
      chk("timeout_early8", {31'd0, err8}, 32'd0);
      @(posedge clk);
      #1;
      chk("timeout_err8", {31'd0, err8}, 32'd1);
      chk("timeout_code8", {30'd0, code8}, 32'd2);
      push_cmd(1'b0, 4'd1, 16'h05, 16'h06);
      fr = '{8'hA5, 8'h01, 8'h05, 8'h06, 8'h02};
      send_frame8(fr);
      chk("after_to_valid8", {31'd0, cv8}, 32'd1);
      chk("after_to_a8", {24'd0, a8}, 32'h05);

      // Overflow while a command is pending.
      push_err(1'b0, 2'd3);
      fr = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h25};
      send_frame8(fr);
      chk("ovf_err8", {31'd0, err8}, 32'd1);
      chk("ovf_code8", {30'd0, code8}, 32'd3);
      chk("ovf_keep_op8", {28'd0, op8}, 32'd1);
      chk("ovf_keep_b8", {24'd0, b8}, 32'h06);

      // Accept in the commit cycle: new command replaces the old, valid stays high.
      push_cmd(1'b0, 4'd3, 16'h12, 16'h34);
      send(1'b0, 8'hA5);
      send(1'b0, 8'h03);
      send(1'b0, 8'h12);
      send(1'b0, 8'h34);
      ready8 = 1'b1;
      send(1'b0, 8'h25);
      ready8 = 1'b0;
      stop_rx();
      chk("swap_valid8", {31'd0, cv8}, 32'd1);
      chk("swap_op8", {28'd0, op8}, 32'd3);
      chk("swap_noerr8", {31'd0, err8}, 32'd0);
      ready8 = 1'b1;
      @(posedge clk);
      #1;
      ready8 = 1'b0;
      chk("swap_drop8", {31'd0, cv8}, 32'd0);

      // 16-bit operands, sync value inside the frame is plain data.
      push_cmd(1'b1, 4'd2, 16'hA501, 16'h00FF);
      send(1'b1, 8'hA5);
      send(1'b1, 8'h02);
      send(1'b1, 8'hA5);
      send(1'b1, 8'h01);
      send(1'b1, 8'h00);
      send(1'b1, 8'hFF);
      send(1'b1, 8'h59);
      stop_rx();
      chk("w16_valid", {31'd0, cv16}, 32'd1);
      chk("w16_a", {16'd0, a16}, 32'hA501);
      chk("w16_b", {16'd0, b16}, 32'h00FF);

      // Reset mid-frame with a command pending.
      send(1'b1, 8'hA5);
      send(1'b1, 8'h02);
      send(1'b1, 8'hA5);
      stop_rx();
      #2;
      rst = 1'b1;
      #1;
      chk("rst16_valid", {31'd0, cv16}, 32'd0);
      chk("rst16_op", {28'd0, op16}, 32'd0);
      chk("rst16_a", {16'd0, a16}, 32'd0);
      chk("rst16_b", {16'd0, b16}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_cmd(1'b1, 4'd1, 16'h0005, 16'h0006);
      send(1'b1, 8'hA5);
      send(1'b1, 8'h01);
      send(1'b1, 8'h00);
      send(1'b1, 8'h05);
      send(1'b1, 8'h00);
      send(1'b1, 8'h06);
      send(1'b1, 8'h02);
      stop_rx();
      chk("post_rst16_valid", {31'd0, cv16}, 32'd1);
      chk("post_rst16_op", {28'd0, op16}, 32'd1);

      repeat (4) @(posedge clk);
      #1;
      chk("q8_drained", q8.size(), 32'd0);
      chk("q16_drained", q16.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_decoder.md
# alu_cmd_decoder

Byte-stream frame decoder downstream of the UART receiver. Consumes one received byte per `rx_valid` pulse and assembles command frames (sync, opcode, operand A, operand B, checksum). Presents a validated `{op, a, b}` command to the ALU through a valid/ready handshake. Malformed or stalled frames are discarded and reported on a one-cycle error strobe.

## Interface
- `DATA_W`, 8 — operand width in bits; multiple of 8, range 8..32; `NB = DATA_W/8` bytes per operand.
- `SYNC_BYTE`, 8'hA5 — frame start marker.
- `TIMEOUT_CLKS`, 50000 — maximum idle cycles between bytes inside a frame (1 ms at 50 MHz).
- `clk` in 1 — system clock, 50 MHz.
- `rst` in 1 — reset, asynchronous, active-high.
- `rx_data` in 8 — received byte; sampled only when `rx_valid` = 1.
- `rx_valid` in 1 — one-cycle strobe per received byte.
- `cmd_op` out 4 — ALU opcode.
- `cmd_a` out DATA_W — operand A.
- `cmd_b` out DATA_W — operand B.
- `cmd_valid` out 1 — command pending; held until accepted.
- `cmd_ready` in 1 — ALU accepts the command on a cycle where `cmd_valid` && `cmd_ready`.
- `err` out 1 — one-cycle error strobe.
- `err_code` out 2 — 0: bad opcode, 1: checksum mismatch, 2: inter-byte timeout, 3: overflow (command dropped). Valid when `err` = 1; otherwise holds the last value.

## Operation
- **Frame format:** `SYNC_BYTE`, opcode byte, A (NB bytes, MSB first), B (NB bytes, MSB first), checksum. The checksum is the XOR of the opcode byte and all A and B bytes; the sync byte is excluded.
- **States:**
  - HUNT: wait for a byte equal to `SYNC_BYTE`, then go to OPCODE. All other bytes are ignored silently.
  - OPCODE: store `rx_data[3:0]` and start the running checksum at `rx_data`, then go to OPA. If `rx_data[7:4]` != 0, flag bad opcode but continue collecting the frame.
  - OPA / OPB: shift `a` or `b` left by 8 and OR in `rx_data`. XOR the byte into the checksum. A byte counter from 0 to NB-1 advances the state after byte NB-1.
  - CHECK: compare `rx_data` with the running checksum, then return to HUNT.
- **Commit** (CHECK byte, checksum equal, opcode flag clear):
  - If `cmd_valid` = 0, or `cmd_ready` = 1 in the same cycle, load the output registers and set `cmd_valid` on the next edge.
  - Otherwise drop the frame and emit `err`/code 3. The pending command is unchanged.
- **CHECK errors:** checksum mismatch gives code 1. A set opcode flag gives code 0 and takes priority over code 1. In both cases nothing is committed.
- **Sync inside a frame:** `SYNC_BYTE` received in any state other than HUNT is treated as ordinary data. There is no resynchronisation mid-frame.
- **Timeout:** the gap counter is cleared on every `rx_valid` and held at 0 in HUNT. It increments otherwise. When it reaches `TIMEOUT_CLKS`, the block returns to HUNT and emits `err`/code 2. If `rx_valid` arrives in the expiry cycle, the byte wins: it is processed and no timeout occurs.
- **Independence:** frame reception continues while a command is pending. `cmd_a`/`cmd_b`/`cmd_op` stay stable while `cmd_valid` = 1.

## Timing
- **Reset values:** state HUNT, `cmd_valid` 0, `cmd_op` 0, `cmd_a` 0, `cmd_b` 0, `err` 0, `err_code` 0, checksum 0, counters 0.
- **Latency:** `cmd_valid` rises one clock after the checksum byte's `rx_valid` cycle.
- **Handshake:** `cmd_valid` falls one clock after an accept cycle, unless a new commit happens in that same cycle, in which case it stays 1 with new data.
- **Error strobe:** `err` is exactly one cycle, registered, and issued one clock after the offending byte or timeout expiry.
- **Reset mid-frame:** the partial frame and any pending command are discarded immediately.
- **Byte rate:** `rx_valid` pulses may be back-to-back (every cycle). The block sustains one byte per clock.

## Structure
- **Package `alu_uart_pkg`:** state enum (HUNT, OPCODE, OPA, OPB, CHECK), error-code enum (ERR_OPCODE, ERR_CSUM, ERR_TIMEOUT, ERR_OVF), default `SYNC_BYTE`.
- **Sub-module `rx_gap_timer`:** parameter `TIMEOUT_CLKS`; inputs `clk`, `rst`, `clear`, `enable`; output one-cycle `expired`. Counter width is `$clog2(TIMEOUT_CLKS+1)`.
- **Top:** FSM, operand shift registers, checksum register, output/commit logic.

## Test plan
All scenarios use `DATA_W` = 8 unless stated.

1. Feed A5 03 12 34 25 with `cmd_ready` = 0 → `cmd_valid` = 1 with `cmd_op` = 3, `cmd_a` = 0x12, `cmd_b` = 0x34. These hold until `cmd_ready` pulses, then `cmd_valid` = 0 one cycle later.
2. Feed 00 7F A5 03 12 34 26 → no command; `err` pulses once with code 1. Leading junk bytes produce no error.
3. Feed A5 13 12 34 35 → `err` code 0, no command.
4. Feed A5 03 12, then idle 50000 cycles → `err` code 2 at expiry, state HUNT. A following valid frame A5 01 05 06 02 → `cmd_op` = 1, `cmd_a` = 5, `cmd_b` = 6.
5. With command 1 pending and `cmd_ready` = 0, send a second valid frame → `err` code 3, outputs unchanged. Repeat with `cmd_ready` = 1 in the commit cycle → new command loaded and `cmd_valid` stays high.
6. With `DATA_W` = 16, feed A5 02 A5 01 00 FF 59 back-to-back → `cmd_a` = 0xA501, `cmd_b` = 0x00FF, `cmd_op` = 2. Assert `rst` mid-frame → all outputs 0 and the next frame decodes cleanly.
